// File: rtl/mem_stream_reader.sv
// Streams `length` consecutive RAM words from `base_addr` (mod DEPTH) onto a valid/ready port.
// Optional read-and-clear build: define MEM_STREAM_READER_CLEAR_EN.
module mem_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wr_en,
  output logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] mem_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [AW-1:0]    addr;     // next address to issue
  logic [AW-1:0]    addr_q;   // last issued address, held on mem_addr when idle
  logic [AW:0]      cnt;      // reads still to issue
  logic             pend;     // read issued last cycle, mem_q valid now
  logic [1:0]       occ;
  logic [WIDTH-1:0] fifo [2];
  logic             rd_ptr, wr_ptr;
  logic             pop, issue, last_pop;
  logic [2:0]       demand;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo[rd_ptr];
  assign busy      = (state == S_RUN);
  assign done      = (state == S_FINISH);

  // Issue only if the word can land in the FIFO: occupancy after this edge stays <= 2.
  assign demand   = {1'b0, occ} + {2'b0, pend};
  assign issue    = (state == S_RUN) && (cnt != '0) && (demand <= ({2'b0, pop} + 3'd1));
  assign last_pop = (cnt == '0) && !pend && (occ == 2'd1) && pop;

  assign mem_addr = issue ? addr : addr_q;
  assign mem_data = '0;
`ifdef MEM_STREAM_READER_CLEAR_EN
  assign mem_wr_en = issue;
`else
  assign mem_wr_en = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      occ     <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr  <= base_addr;
          cnt   <= length;
          state <= (length == '0) ? S_FINISH : S_RUN;
        end
        S_RUN:    if (last_pop) state <= S_FINISH;
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (issue) begin
        addr_q <= addr;
        addr   <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
        cnt    <= cnt - 1'b1;
      end
      pend <= issue;
      if (pend) begin
        fifo[wr_ptr] <= mem_q;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, pend} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: RAM model, queue-based stream model, random + directed transfers.
module tb_mem_stream_reader;
  localparam int W  = 8;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int LW = AW + 1;

  logic          clock, reset, start, busy, done, mem_wr_en, out_valid, out_ready;
  logic [AW-1:0] base_addr, mem_addr;
  logic [AW:0]   length;
  logic [W-1:0]  mem_data, mem_q, out_data;

  logic [W-1:0] ram [D];
  logic [W-1:0] exp_q [$];
  int           got_d [$];
  int           got_c [$];
  int tests = 0, fails = 0, done_cnt = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_data;

  mem_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_data(mem_data),
    .mem_q(mem_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Single-port RAM, 1-cycle read latency, returns old word on write.
  always @(posedge clock) begin
    mem_q <= ram[mem_addr];
    if (mem_wr_en) ram[mem_addr] <= mem_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every accepted word against the model queue, plus hold/stability rules.
  always @(negedge clock) begin
    if (reset) prev_stall = 0;
    else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("stream_data", int'(out_data), int'(exp_q.pop_front()));
      end
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        chk("done_while_busy", int'(busy), 0);
      end
`ifndef MEM_STREAM_READER_CLEAR_EN
      chk("wr_en_zero", int'(mem_wr_en), 0);
`endif
      chk("wr_data_zero", int'(mem_data), 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic xfer(input int b, input int l, input int mode, input bit poke, output int dn);
    int n, a0, wr;
    got_d.delete();
    got_c.delete();
    for (int k = 0; k < l; k++) exp_q.push_back(ram[(b + k) % D]);
    a0 = int'(mem_addr);
    dn = -1;
    wr = 0;
    n  = 0;
    start = 1; base_addr = AW'(b); length = LW'(l); out_ready = 1;
    while (dn < 0 && n < 6 * l + 60) begin
      tick();
      n++;
      start = poke && (n == 2);
      if (poke && n == 2) begin
        base_addr = AW'(0);
        length    = LW'(1);
      end
      case (mode)
        0:       out_ready = 1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(n >= 8 && n <= 17) && (n % 3 == 1);
      endcase
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data));
        got_c.push_back(n);
      end
      if (mem_wr_en) wr++;
      if (l == 0) begin
        chk("len0_busy", int'(busy), 0);
        chk("len0_addr", int'(mem_addr), a0);
      end
      if (l > 0 && n >= 1 && dn < 0 && !done) chk("busy_during", int'(busy), 1);
      if (done) dn = n;
    end
    start = 0;
    chk("done_seen", int'(dn >= 0), 1);
    if (mode == 0) begin
      chk("done_cycle", dn, (l == 0) ? 1 : 3 + l);
      for (int k = 0; k < got_c.size(); k++) chk("word_cycle", got_c[k], 3 + k);
    end
    chk("word_count", got_d.size(), l);
    chk("model_drained", exp_q.size(), 0);
    tick();
    chk("done_pulse", int'(done), 0);
    chk("busy_after", int'(busy), 0);
`ifdef MEM_STREAM_READER_CLEAR_EN
    chk("clear_writes", wr, l);
    for (int k = 0; k < l; k++) chk("cleared", int'(ram[(b + k) % D]), 0);
`endif
  endtask

  task automatic ram_ramp(input int ofs);
    for (int i = 0; i < D; i++) ram[i] = W'(i + ofs);
  endtask

  task automatic lit(input string name, input int k, input int exp);
    if (got_d.size() > k) chk(name, got_d[k], exp);
    else chk({name, "_missing"}, got_d.size(), k + 1);
  endtask

  initial begin
    int dn, dc0;
    int wexp [4];
    reset = 1; start = 0; base_addr = '0; length = '0; out_ready = 0;
    ram_ramp(0);
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_wdata", int'(mem_data), 0);
    reset = 0;
    tick();

    // Basic: 3,4,5,6 in cycles 3..6, done in 7.
    ram_ramp(0);
    xfer(3, 4, 0, 0, dn);
    for (int k = 0; k < 4; k++) lit("basic_word", k, 3 + k);
    chk("basic_done_cycle", dn, 7);

    // Wrap across the top of the RAM.
    ram_ramp(0);
    wexp[0] = 62; wexp[1] = 63; wexp[2] = 0; wexp[3] = 1;
    xfer(62, 4, 0, 0, dn);
    for (int k = 0; k < 4; k++) lit("wrap_word", k, wexp[k]);

    // Full depth.
    for (int i = 0; i < D; i++) ram[i] = W'($urandom);
    xfer(0, 64, 0, 0, dn);

    // Backpressure pattern with a 10-cycle low window.
    ram_ramp(0);
    xfer(40, 8, 2, 0, dn);
    for (int k = 0; k < 8; k++) lit("bp_word", k, 40 + k);

    // length 0 and start while busy.
    xfer(10, 0, 0, 0, dn);
    chk("len0_done_cycle", dn, 1);
    ram_ramp(0);
    xfer(20, 6, 0, 1, dn);
    for (int k = 0; k < 6; k++) lit("poke_word", k, 20 + k);

    // Reset mid-transfer.
    ram_ramp(0);
    for (int k = 0; k < 10; k++) exp_q.push_back(ram[5 + k]);
    start = 1; base_addr = AW'(5); length = LW'(10); out_ready = 1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      start = 0;
      if (n == 4) reset = 1;
    end
    tick();
    reset = 0;
    exp_q.delete();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_addr", int'(mem_addr), 0);
    dc0 = done_cnt;
    repeat (6) tick();
    chk("mid_rst_no_done", done_cnt, dc0);
    xfer(0, 2, 0, 0, dn);
    lit("post_rst_word", 0, 0);
    lit("post_rst_word", 1, 1);

`ifdef MEM_STREAM_READER_CLEAR_EN
    ram_ramp(1);
    xfer(0, 4, 0, 0, dn);
    for (int k = 0; k < 4; k++) lit("clr_word", k, k + 1);
    chk("clr_untouched", int'(ram[4]), 5);
`endif

    // Randomized transfers.
    for (int it = 0; it < 15; it++) begin
      int b, l, m;
      for (int i = 0; i < D; i++) ram[i] = W'($urandom);
      b = $urandom_range(0, D - 1);
      l = $urandom_range(0, D);
      m = $urandom_range(0, 2);
      xfer(b, l, m, (l > 0) && ($urandom_range(0, 1) == 1), dn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
